axi4lite_master: RTL and testbench
==================================

// Module: axi4lite_master
// PURPOSE
//  Initiator end of the AXI4-Lite link. Converts single-beat read/write commands from a local
//  valid/ready command port into AXI4-Lite transactions, and returns the data/response on a
//  local response port. One transaction outstanding at a time. Drives the slave side of the bus.
// PARAMETERS
//  ADDR_W          32                    address width (AW_ADDR, AR_ADDR, CMD_ADDR)
//  DATA_W          AXI_DATA_WIDTH (32)   data width; STRB width = DATA_W/8
//  ERR_CNT_W       16                    width of error counter (optional feature only)
// PORTS
//  A_CLK        in   1         clock, all logic rising-edge
//  A_RST        in   1         reset; one clock, asynchronous, active-high
//  CMD_VALID    in   1         command offered
//  CMD_READY    out  1         command accepted when VALID&READY
//  CMD_WRITE    in   1         1 = write, 0 = read
//  CMD_ADDR     in   ADDR_W    transaction address
//  CMD_WDATA    in   DATA_W    write data (ignored for reads)
//  CMD_WSTRB    in   DATA_W/8  write byte strobes
//  RSP_VALID    out  1         response available
//  RSP_READY    in   1         response consumed when VALID&READY
//  RSP_WRITE    out  1         response belongs to a write
//  RSP_RDATA    out  DATA_W    read data (0 for writes)
//  RSP_RESP     out  2         B_RESP or R_RESP as received
//  AW_VALID/AW_READY out/in 1; AW_ADDR out ADDR_W; AW_PROT out 3 (constant 3'b000)
//  W_VALID/W_READY   out/in 1; W_DATA out DATA_W;  W_STRB out DATA_W/8
//  B_VALID in 1; B_READY out 1; B_RESP in 2
//  AR_VALID/AR_READY out/in 1; AR_ADDR out ADDR_W; AR_PROT out 3 (constant 3'b000)
//  R_VALID in 1; R_READY out 1; R_DATA in DATA_W; R_RESP in 2
//  ERR_CNT      out  ERR_CNT_W count of non-OKAY responses (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all *_VALID, B_READY, R_READY, RSP_* = 0; CMD_READY = 0 while A_RST high.
//  States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
//  IDLE: CMD_READY=1. On CMD handshake: latch addr/data/strb/write -> WR_REQ (write) or RD_REQ.
//  WR_REQ: AW_VALID and W_VALID both rise the cycle after CMD handshake (registered).
//   Each drops the cycle after its own handshake; the other stays high until its handshake.
//   Both-done (same or different cycles) -> WR_RESP. Order of AW vs W completion is free.
//  WR_RESP: B_READY=1; on B handshake latch B_RESP, RSP_WRITE=1, RSP_RDATA=0 -> RSP.
//  RD_REQ: AR_VALID high until AR handshake -> RD_RESP.
//  RD_RESP: R_READY=1; on R handshake latch R_DATA/R_RESP, RSP_WRITE=0 -> RSP.
//  RSP: RSP_VALID=1 with stable payload until RSP_READY; then -> IDLE (CMD_READY next cycle).
//  Min latency CMD handshake -> RSP_VALID: 3 cycles with slave READY/VALID always high.
//  VALID never deasserts before its handshake; AW/W/AR payload stable while VALID high.
//  B_VALID/R_VALID outside WR_RESP/RD_RESP are ignored (READY low); no effect on state.
//  A_RST mid-transaction: all outputs return to reset values immediately; command dropped,
//   no response issued; bus slave must also be reset.
// CONFIGURATION
//  AXI4LITE_MASTER_ERR_CNT_EN defined: ERR_CNT increments on each B/R handshake with RESP!=2'b00,
//   saturates at all-ones, reset to 0. Undefined: ERR_CNT tied to 0, no counter logic.
// STRUCTURE
//  Package axi4lite_pkg: AXI_DATA_WIDTH, resp enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3),
//   state_t of this block. No sub-module; single FSM plus payload registers.
// TESTING
//  Write 0x10/0xDEADBEEF, strb 0xF, slave AW_READY cycle 1, W_READY cycle 3 -> AW_VALID drops
//   after cycle 1, W_VALID held to cycle 3, then B_READY; RSP_VALID, RSP_WRITE=1, RSP_RESP=00.
//  Read 0x20, AR_READY after 2 wait cycles, R_DATA=0x12345678 RESP=00 -> RSP_RDATA=0x12345678.
//  Read with R_RESP=2'b10, RSP_READY held low 4 cycles -> RSP_VALID/payload stable 4 cycles;
//   ERR_CNT=1 with AXI4LITE_MASTER_ERR_CNT_EN, 0 without.
//  Back-to-back write then read, all READYs high -> RSP_VALID 3 cycles after each CMD handshake.
//  Spurious B_VALID in IDLE, then A_RST asserted mid WR_REQ -> no B_READY, VALIDs 0 at once, IDLE.
//  ERR_CNT_W=2, 5 SLVERR responses -> ERR_CNT saturates at 3.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite master: bus data width, response codes, FSM states.
package axi4lite_pkg;

    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator: one single-beat command in flight, local cmd/rsp handshake ports.
// Optional error counter on ERR_CNT is built when AXI4LITE_MASTER_ERR_CNT_EN is defined.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = AXI_DATA_WIDTH,
    parameter int ERR_CNT_W = 16
) (
    input  logic                  A_CLK,
    input  logic                  A_RST,
    // local command port
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_W-1:0]     CMD_ADDR,
    input  logic [DATA_W-1:0]     CMD_WDATA,
    input  logic [DATA_W/8-1:0]   CMD_WSTRB,
    // local response port
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_WRITE,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic [1:0]            RSP_RESP,
    // write address channel
    output logic                  AW_VALID,
    input  logic                  AW_READY,
    output logic [ADDR_W-1:0]     AW_ADDR,
    output logic [2:0]            AW_PROT,
    // write data channel
    output logic                  W_VALID,
    input  logic                  W_READY,
    output logic [DATA_W-1:0]     W_DATA,
    output logic [DATA_W/8-1:0]   W_STRB,
    // write response channel
    input  logic                  B_VALID,
    output logic                  B_READY,
    input  logic [1:0]            B_RESP,
    // read address channel
    output logic                  AR_VALID,
    input  logic                  AR_READY,
    output logic [ADDR_W-1:0]     AR_ADDR,
    output logic [2:0]            AR_PROT,
    // read data channel
    input  logic                  R_VALID,
    output logic                  R_READY,
    input  logic [DATA_W-1:0]     R_DATA,
    input  logic [1:0]            R_RESP,
    // error statistics
    output logic [ERR_CNT_W-1:0]  ERR_CNT
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state_q, state_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    resp_t               rsp_resp_q, rsp_resp_d;
    logic                aw_done, w_done;

    // Next-state and payload capture; channel VALIDs are registered so they rise
    // the cycle after the command handshake and fall the cycle after their own.
    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        aw_done     = !aw_valid_q || AW_READY;
        w_done      = !w_valid_q || W_READY;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    addr_d  = CMD_ADDR;
                    wdata_d = CMD_WDATA;
                    wstrb_d = CMD_WSTRB;
                    if (CMD_WRITE) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in either order
                if (aw_valid_q && AW_READY) aw_valid_d = 1'b0;
                if (w_valid_q && W_READY)   w_valid_d  = 1'b0;
                if (aw_done && w_done)      state_d    = WR_RESP;
            end
            WR_RESP: begin
                if (B_VALID) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = resp_t'(B_RESP);
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (AR_READY) begin
                    ar_valid_d = 1'b0;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                if (R_VALID) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = R_DATA;
                    rsp_resp_d  = resp_t'(R_RESP);
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (RSP_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and payload registers; reset drops any transaction in flight.
    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            state_q     <= IDLE;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            state_q     <= state_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // READY/VALID that follow the state directly; CMD_READY is held low during reset.
    assign CMD_READY = (state_q == IDLE) && !A_RST;
    assign B_READY   = (state_q == WR_RESP);
    assign R_READY   = (state_q == RD_RESP);
    assign RSP_VALID = (state_q == RSP);

    assign AW_VALID  = aw_valid_q;
    assign AW_ADDR   = addr_q;
    assign AW_PROT   = 3'b000;
    assign W_VALID   = w_valid_q;
    assign W_DATA    = wdata_q;
    assign W_STRB    = wstrb_q;
    assign AR_VALID  = ar_valid_q;
    assign AR_ADDR   = addr_q;
    assign AR_PROT   = 3'b000;

    assign RSP_WRITE = rsp_write_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_RESP  = rsp_resp_q;

`ifdef AXI4LITE_MASTER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_evt;

    // Count non-OKAY B/R handshakes, saturating at all-ones.
    always_comb begin
        err_evt   = (B_VALID && B_READY && (B_RESP != OKAY)) ||
                    (R_VALID && R_READY && (R_RESP != OKAY));
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    // Error counter register.
    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign ERR_CNT = err_cnt_q;
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: directed scenarios plus randomized traffic against a
// bus-slave memory and an independent command-level reference memory.
module tb_axi4lite_master;

    logic        A_CLK, A_RST;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic [3:0]  CMD_WSTRB;
    logic        RSP_VALID, RSP_READY, RSP_WRITE;
    logic [31:0] RSP_RDATA;
    logic [1:0]  RSP_RESP;
    logic        AW_VALID, AW_READY;
    logic [31:0] AW_ADDR;
    logic [2:0]  AW_PROT;
    logic        W_VALID, W_READY;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic        B_VALID, B_READY;
    logic [1:0]  B_RESP;
    logic        AR_VALID, AR_READY;
    logic [31:0] AR_ADDR;
    logic [2:0]  AR_PROT;
    logic        R_VALID, R_READY;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;
    logic [1:0]  ERR_CNT;

    axi4lite_master #(.ADDR_W(32), .DATA_W(32), .ERR_CNT_W(2)) dut (
        .A_CLK(A_CLK), .A_RST(A_RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
        .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
        .ERR_CNT(ERR_CNT)
    );

    initial A_CLK = 1'b0;
    always #5 A_CLK = ~A_CLK;

    int checks = 0;
    int errors = 0;
    int err_exp = 0;
    logic [31:0] ref_mem   [16];   // what the commands say memory should hold
    logic [31:0] slave_mem [16];   // what the bus actually delivered

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge A_CLK);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [1:0] exp_err();
`ifdef AXI4LITE_MASTER_ERR_CNT_EN
        return 2'(err_exp);
`else
        return 2'd0;
`endif
    endfunction

    function automatic void note_resp(input logic [1:0] r);
        if (r != 2'b00 && err_exp < 3) err_exp++;
    endfunction

    // Holds the response for 'hold' cycles, checking it stays put, then consumes it.
    task automatic rsp_phase(input logic wr, input logic [31:0] rd, input logic [1:0] rs,
                             input int hold);
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", RSP_VALID, 1);
            chk("rsp_write", RSP_WRITE, wr);
            chk("rsp_rdata", RSP_RDATA, rd);
            chk("rsp_resp", RSP_RESP, rs);
            chk("cmd_ready_rsp", CMD_READY, 0);
            chk("err_cnt", ERR_CNT, exp_err());
            RSP_READY = (h == hold);
            step();
            RSP_READY = 1'b0;
        end
        chk("rsp_valid_done", RSP_VALID, 0);
        chk("cmd_ready_back", CMD_READY, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dl, input int w_dl, input int b_dl,
                            input logic [1:0] resp, input int hold);
        logic [31:0] cap_a, cap_d;
        logic [3:0]  cap_s;
        bit aw_done, w_done;
        int m;
        m = (aw_dl > w_dl) ? aw_dl : w_dl;
        cap_a = 0; cap_d = 0; cap_s = 0;
        chk("cmd_ready_idle", CMD_READY, 1);
        CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s;
        step();
        CMD_VALID = 0; CMD_ADDR = $urandom; CMD_WDATA = $urandom; CMD_WSTRB = 4'($urandom);
        aw_done = 0; w_done = 0;
        for (int k = 0; k <= m; k++) begin
            chk("aw_valid", AW_VALID, !aw_done);
            chk("w_valid", W_VALID, !w_done);
            chk("b_ready_req", B_READY, 0);
            chk("rsp_valid_req", RSP_VALID, 0);
            if (!aw_done) begin chk("aw_addr", AW_ADDR, a); chk("aw_prot", AW_PROT, 0); end
            if (!w_done) begin chk("w_data", W_DATA, d); chk("w_strb", W_STRB, s); end
            AW_READY = (k == aw_dl);
            W_READY  = (k == w_dl);
            if (AW_READY && AW_VALID) cap_a = AW_ADDR;
            if (W_READY && W_VALID) begin cap_d = W_DATA; cap_s = W_STRB; end
            step();
            if (k == aw_dl) aw_done = 1;
            if (k == w_dl) w_done = 1;
            AW_READY = 0; W_READY = 0;
        end
        slave_mem[cap_a[5:2]] = merge(slave_mem[cap_a[5:2]], cap_d, cap_s);
        ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
        for (int j = 0; j <= b_dl; j++) begin
            chk("aw_valid_off", AW_VALID, 0);
            chk("w_valid_off", W_VALID, 0);
            chk("b_ready", B_READY, 1);
            chk("rsp_valid_b", RSP_VALID, 0);
            B_VALID = (j == b_dl);
            B_RESP  = (j == b_dl) ? resp : 2'($urandom);
            step();
            B_VALID = 0;
        end
        note_resp(resp);
        rsp_phase(1'b1, 32'h0, resp, hold);
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_dl, input int r_dl,
                           input logic [1:0] resp, input int hold);
        logic [31:0] cap_a;
        cap_a = 0;
        chk("cmd_ready_idle", CMD_READY, 1);
        CMD_VALID = 1; CMD_WRITE = 0; CMD_ADDR = a; CMD_WDATA = $urandom;
        step();
        CMD_VALID = 0; CMD_ADDR = $urandom;
        for (int k = 0; k <= ar_dl; k++) begin
            chk("ar_valid", AR_VALID, 1);
            chk("ar_addr", AR_ADDR, a);
            chk("ar_prot", AR_PROT, 0);
            chk("aw_valid_rd", AW_VALID, 0);
            chk("r_ready_req", R_READY, 0);
            AR_READY = (k == ar_dl);
            if (AR_READY) cap_a = AR_ADDR;
            step();
            AR_READY = 0;
        end
        for (int j = 0; j <= r_dl; j++) begin
            chk("ar_valid_off", AR_VALID, 0);
            chk("r_ready", R_READY, 1);
            chk("rsp_valid_r", RSP_VALID, 0);
            R_VALID = (j == r_dl);
            R_DATA  = (j == r_dl) ? slave_mem[cap_a[5:2]] : $urandom;
            R_RESP  = (j == r_dl) ? resp : 2'($urandom);
            step();
            R_VALID = 0;
        end
        note_resp(resp);
        rsp_phase(1'b0, ref_mem[a[5:2]], resp, hold);
    endtask

    // Watchdog: the sequence below is bounded, this only guards against a hung simulator.
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        A_RST = 1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0; CMD_WSTRB = 0;
        RSP_READY = 0; AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
        AR_READY = 0; R_VALID = 0; R_DATA = 0; R_RESP = 0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            slave_mem[i] = v;
        end
        ref_mem[8] = 32'h12345678;
        slave_mem[8] = 32'h12345678;

        // reset values
        #1;
        chk("rst_cmd_ready", CMD_READY, 0);
        chk("rst_aw_valid", AW_VALID, 0);
        chk("rst_w_valid", W_VALID, 0);
        chk("rst_ar_valid", AR_VALID, 0);
        chk("rst_b_ready", B_READY, 0);
        chk("rst_r_ready", R_READY, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_payload", {RSP_WRITE, RSP_RDATA, RSP_RESP}, 0);
        chk("rst_err_cnt", ERR_CNT, 0);
        step(); step();
        A_RST = 0;
        #1;
        chk("post_rst_cmd_ready", CMD_READY, 1);

        // directed write with AW accepted in cycle 1 and W in cycle 3
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 1, 3, 0, 2'b00, 0);
        // read with two AR wait cycles
        do_read(32'h20, 2, 0, 2'b00, 0);
        chk("read_0x20_value", RSP_RDATA, 32'h12345678);
        // SLVERR read with the response stalled four cycles
        do_read(32'h24, 0, 1, 2'b10, 4);
        // back-to-back, everything ready: response three cycles after each command
        do_write(32'h28, 32'hA5A5_0F0F, 4'b0101, 0, 0, 0, 2'b00, 0);
        do_read(32'h28, 0, 0, 2'b00, 0);
        do_write(32'h2C, 32'h0BAD_F00D, 4'b1000, 2, 0, 1, 2'b00, 0);
        // five SLVERRs drive the 2-bit counter into saturation
        for (int i = 0; i < 5; i++) do_read(32'(i * 4), 0, 0, 2'b10, 0);
        chk("err_cnt_saturated", ERR_CNT, exp_err());

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [1:0]  rs;
            a  = 32'($urandom_range(0, 15) * 4);
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2), rs, $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rs, $urandom_range(0, 2));
        end

        // stray B/R VALID while idle must be ignored
        B_VALID = 1; B_RESP = 2'b10; R_VALID = 1; R_RESP = 2'b11; R_DATA = $urandom;
        for (int i = 0; i < 3; i++) begin
            chk("spur_b_ready", B_READY, 0);
            chk("spur_r_ready", R_READY, 0);
            chk("spur_cmd_ready", CMD_READY, 1);
            chk("spur_err_cnt", ERR_CNT, exp_err());
            step();
        end
        B_VALID = 0; R_VALID = 0;
        chk("spur_rsp_valid", RSP_VALID, 0);

        // reset in the middle of a write request
        CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h30; CMD_WDATA = 32'hFFFF_FFFF; CMD_WSTRB = 4'hF;
        step();
        CMD_VALID = 0;
        chk("mid_aw_valid", AW_VALID, 1);
        chk("mid_w_valid", W_VALID, 1);
        #2;
        A_RST = 1;
        #1;
        chk("arst_aw_valid", AW_VALID, 0);
        chk("arst_w_valid", W_VALID, 0);
        chk("arst_cmd_ready", CMD_READY, 0);
        chk("arst_b_ready", B_READY, 0);
        chk("arst_rsp_valid", RSP_VALID, 0);
        chk("arst_err_cnt", ERR_CNT, 0);
        err_exp = 0;
        step();
        A_RST = 0;
        #1;
        chk("after_rst_cmd_ready", CMD_READY, 1);
        step();
        chk("after_rst_aw_valid", AW_VALID, 0);
        chk("after_rst_rsp_valid", RSP_VALID, 0);

        // dropped write must not have reached memory; link still works
        do_read(32'h30, 1, 1, 2'b00, 1);
        do_write(32'h30, 32'h5555_AAAA, 4'b0011, 0, 1, 0, 2'b01, 0);
        do_read(32'h30, 0, 0, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
